jtopl_slot_sched: RTL and testbench
===================================

# jtopl_slot_sched

Slot sequencer and register-write scheduler for the JTOPL operator pipeline. It steps the 18-slot operator index once per `cen`, decodes group/sub-slot/operator/channel for the per-slot shift-register stages, and holds one pending host register write until the pipeline is at the targeted slot. It then presents that write to the slot register file for exactly one slot period. It sits between the CPU interface and the operator/envelope/phase pipelines.

## Interface
- `SLOTS`, 18: slots per frame; must equal the delay-line stage count of the slot pipelines
- `DW`, 8: register data width
- `rst`  in  1  synchronous, active-high reset
- `clk`  in  1  clock; all state changes on rising edge
- `cen`  in  1  clock enable; one slot advance per `cen` cycle
- `wr`  in  1  write request, sampled on every `clk` edge (not `cen`-gated)
- `wr_glb`  in  1  write targets a global (non-slot) register
- `wr_slot`  in  5  target slot, 0..SLOTS-1; ignored when `wr_glb`=1
- `wr_sel`  in  3  register field selector inside the slot/global map
- `wr_data`  in  DW  write data
- `busy`  out  1  a write is pending; new writes ignored
- `slot`  out  5  current slot, 0..SLOTS-1
- `group`  out  2  slot/6
- `sub`  out  3  slot%6
- `op`  out  1  1 when sub>=3 (carrier), 0 for modulator
- `ch`  out  4  group*3 + sub%3
- `zero`  out  1  high for the slot period in which slot==0, after a wrap
- `upd_en`  out  1  pending write valid for this slot period
- `upd_glb`, `upd_sel`, `upd_slot`, `upd_data`  out  1/3/5/DW  latched write fields

## Operation
- Reset (synchronous, `rst`=1 at an edge): slot=0, zero=0, busy=0, all latched write fields 0. Decodes follow slot (group=0, sub=0, op=0, ch=0). `upd_en`=0. Any pending write is dropped.
- Sequencer: on each edge with `cen`=1, slot <= (slot==SLOTS-1) ? 0 : slot+1. zero <= (slot==SLOTS-1). With `cen`=0, everything holds.
- Decodes are combinational from registered `slot`.
- Write accept: at an edge with `wr`=1, busy=0, rst=0:
  - If `wr_glb`=1 or `wr_slot`<SLOTS: latch all write fields and set busy=1.
  - If `wr_glb`=0 and `wr_slot`>=SLOTS: ignore; busy stays 0.
- At an edge where `wr`=1 and busy=1: ignored, even if busy clears at that same edge.
- `upd_en` = busy & (upd_glb | slot==upd_slot), combinational from registers.
- Apply: at an edge with `cen`=1 and `upd_en`=1, busy <= 0. The consumer samples the `upd_*` fields on that same `cen` edge.
- Global writes therefore apply at the first `cen` edge after acceptance. Slot writes apply at the `cen` edge that ends the targeted slot period.
- `upd_*` fields hold their last value after apply; only `upd_en` qualifies them.

## Timing
- Slot advance latency: 1 `cen` edge.
- Acceptance: busy visible high 1 clk after the `wr` edge.
- Worst-case slot-write latency: SLOTS `cen` periods, when the target slot has just passed.
- If slot==upd_slot in the same clk that busy rises, `upd_en` is high immediately. The write applies at the next `cen` edge.
- `cen`=0 for any duration: busy and `upd_en` hold; no write is lost.
- `cen` held high continuously: one slot per clk; `zero` pulses every SLOTS clks, one clk wide.
- Reset mid-pending: busy=0 and `upd_en`=0 at the reset edge; no apply occurs.

## Test plan
- Reset then `cen` every clk for 40 clks -> slot sequence 1,2,…,17,0,1…; `zero` high exactly on clks where slot==0 after wrap. ch/op at slot 4 = 1/1; at slot 13 = 7/0.
- Slot 9 is on screen; write with `wr_slot`=5, `wr_data`=0xA5, `cen` every clk -> busy high for 14 clks. `upd_en` high only during slot 5 with `upd_data`=0xA5. busy low after that edge.
- Global write, `wr_sel`=3, with `cen` every 4th clk -> `upd_en` high until the next `cen` edge, then busy=0; slot target ignored.
- Second `wr` while busy, including on the apply edge -> dropped; first write's data is the only one applied. Invalid `wr_slot`=20 -> busy stays 0.
- Pending write to slot 2, then `rst` pulse before slot 2 -> busy=0, slot=0, no `upd_en` pulse through 2 full frames.
- `cen` held low for 100 clks with write pending to the current slot -> `upd_en` stays high, busy holds, slot frozen; applies on the first `cen` edge.

Source files
------------

// File: rtl/jtopl_slot_sched.sv
// -----------------------------------------------------------------------------
// jtopl_slot_sched
//
// Slot sequencer and register-write scheduler for the JTOPL operator pipeline.
// A free-running slot index steps once per clock enable and is decoded into the
// group / sub-slot / operator / channel fields used by the per-slot shift
// register stages. One host register write at a time is held here until the
// pipeline reaches the targeted slot. It is then offered to the slot register
// file for exactly one slot period.
//
// Ports
//   rst       synchronous, active-high reset
//   clk       clock; all state changes on the rising edge
//   cen       clock enable; one slot advance per enabled cycle
//   wr        write request, sampled on every clk edge (not cen-gated)
//   wr_glb    write targets a global (non-slot) register
//   wr_slot   target slot 0..SLOTS-1 (ignored for global writes)
//   wr_sel    register field selector
//   wr_data   write data
//   busy      a write is pending; new requests are ignored
//   slot      current slot 0..SLOTS-1
//   group     slot / 6
//   sub       slot % 6
//   op        1 for carrier (sub >= 3), 0 for modulator
//   ch        group*3 + sub%3
//   zero      high for the slot period in which slot==0, after a wrap
//   upd_en    pending write is valid for the current slot period
//   upd_glb, upd_sel, upd_slot, upd_data
//             latched write fields; qualified only by upd_en
// -----------------------------------------------------------------------------
module jtopl_slot_sched #(
  parameter int SLOTS = 18,
  parameter int DW    = 8
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          wr,
  input  logic          wr_glb,
  input  logic [4:0]    wr_slot,
  input  logic [2:0]    wr_sel,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic [4:0]    slot,
  output logic [1:0]    group,
  output logic [2:0]    sub,
  output logic          op,
  output logic [3:0]    ch,
  output logic          zero,
  output logic          upd_en,
  output logic          upd_glb,
  output logic [2:0]    upd_sel,
  output logic [4:0]    upd_slot,
  output logic [DW-1:0] upd_data
);

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [4:0] NUM_SLOTS = 5'(SLOTS);

  logic wr_valid;  // request addresses something that exists
  logic accept;    // request is taken at this edge
  logic apply;     // pending write is consumed at this edge

  // ---------------------------------------------------------------------------
  // Slot sequencer
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers sample pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      zero <= 1'b0;
    end else if (cen) begin
      slot <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
      // zero marks the slot-0 period that follows a wrap, not the reset one.
      zero <= (slot == LAST_SLOT);
    end
  end

  // ---------------------------------------------------------------------------
  // Slot decodes (combinational from the registered slot)
  // ---------------------------------------------------------------------------
  always_comb begin
    group = 2'(slot / 5'd6);
    sub   = 3'(slot % 5'd6);
    op    = (sub >= 3'd3);
    ch    = 4'(group) * 4'd3 + 4'(sub % 3'd3);
  end

  // ---------------------------------------------------------------------------
  // Write scheduler
  // ---------------------------------------------------------------------------
  // Out-of-range slot targets are dropped at the door so they can never sit
  // pending forever waiting for a slot that never comes.
  assign wr_valid = wr_glb | (wr_slot < NUM_SLOTS);

  // A request that lands while busy is lost, including on the apply edge: the
  // decision uses the pre-edge busy value.
  assign accept = wr & ~busy & wr_valid;

  // Global writes do not wait for a slot; slot writes wait for their period.
  assign upd_en = busy & (upd_glb | (slot == upd_slot));

  // The consumer samples upd_* on this same cen edge.
  assign apply = cen & upd_en;

  // NOTE: the latched fields are reset as well even though upd_en qualifies
  // them, so the outputs are deterministic from reset onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      upd_glb  <= 1'b0;
      upd_sel  <= '0;
      upd_slot <= '0;
      upd_data <= '0;
    end else if (accept) begin
      busy     <= 1'b1;
      upd_glb  <= wr_glb;
      upd_sel  <= wr_sel;
      upd_slot <= wr_slot;
      upd_data <= wr_data;
    end else if (apply) begin
      // Fields keep their last value; only busy is released.
      busy     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtopl_slot_sched.sv
// -----------------------------------------------------------------------------
// tb_jtopl_slot_sched
//
// Self-checking bench for jtopl_slot_sched. A behavioural model tracks the
// current slot as an integer and the pending write as a small record; outputs
// are derived from them with plain arithmetic and compared after every edge.
// Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_jtopl_slot_sched;

  localparam int SLOTS = 18;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst, cen, wr, wr_glb;
  logic [4:0]    wr_slot;
  logic [2:0]    wr_sel;
  logic [DW-1:0] wr_data;
  logic          busy, op, zero, upd_en, upd_glb;
  logic [4:0]    slot, upd_slot;
  logic [1:0]    group;
  logic [2:0]    sub, upd_sel;
  logic [3:0]    ch;
  logic [DW-1:0] upd_data;

  jtopl_slot_sched #(.SLOTS(SLOTS), .DW(DW)) dut (
    .rst(rst), .clk(clk), .cen(cen), .wr(wr), .wr_glb(wr_glb),
    .wr_slot(wr_slot), .wr_sel(wr_sel), .wr_data(wr_data),
    .busy(busy), .slot(slot), .group(group), .sub(sub), .op(op), .ch(ch),
    .zero(zero), .upd_en(upd_en), .upd_glb(upd_glb), .upd_sel(upd_sel),
    .upd_slot(upd_slot), .upd_data(upd_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit glb;
    int sel;
    int tslot;
    int data;
  } wr_t;

  int  m_slot;
  bit  m_zero;
  bit  m_busy;
  wr_t m_wr;
  int  applied[$];   // data of every write the model saw being applied

  function automatic bit m_upd_en();
    return m_busy && (m_wr.glb || m_slot == m_wr.tslot);
  endfunction

  task automatic model_edge();
    bit was_busy, en;
    was_busy = m_busy;
    en       = m_upd_en();
    if (rst) begin
      m_slot = 0;
      m_zero = 0;
      m_busy = 0;
      m_wr   = '{0, 0, 0, 0};
    end else begin
      if (cen) begin
        m_zero = (m_slot == SLOTS - 1);
        m_slot = (m_slot + 1) % SLOTS;
        if (en) begin
          m_busy = 0;
          applied.push_back(m_wr.data);
        end
      end
      if (wr && !was_busy && (wr_glb || int'(wr_slot) < SLOTS)) begin
        m_busy = 1;
        m_wr   = '{wr_glb, int'(wr_sel), int'(wr_slot), int'(wr_data)};
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("slot",     32'(slot),     32'(m_slot));
    check("group",    32'(group),    32'(m_slot / 6));
    check("sub",      32'(sub),      32'(m_slot % 6));
    check("op",       32'(op),       32'((m_slot % 6) >= 3));
    check("ch",       32'(ch),       32'((m_slot / 6) * 3 + (m_slot % 6) % 3));
    check("zero",     32'(zero),     32'(m_zero));
    check("busy",     32'(busy),     32'(m_busy));
    check("upd_en",   32'(upd_en),   32'(m_upd_en()));
    check("upd_glb",  32'(upd_glb),  32'(m_wr.glb));
    check("upd_sel",  32'(upd_sel),  32'(m_wr.sel));
    check("upd_slot", 32'(upd_slot), 32'(m_wr.tslot));
    check("upd_data", 32'(upd_data), 32'(m_wr.data));
  endtask

  // One clock edge: model follows the same inputs, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 0; cen = 0; wr = 0; wr_glb = 0;
    wr_slot = '0; wr_sel = '0; wr_data = '0;
  endtask

  task automatic run_to_slot(input int target);
    int guard;
    guard = 0;
    cen = 1;
    while (m_slot != target && guard < 2 * SLOTS) begin
      tick();
      guard++;
    end
    if (m_slot != target) check("run_to_slot_timeout", 1, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cnt, n0, guard, cyc, saved;

    idle_inputs();
    m_slot = 0; m_zero = 0; m_busy = 0; m_wr = '{0, 0, 0, 0};

    // Reset state
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Sequencer: cen every clk for 40 clks
    cen = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_slot == 4) begin
        check("ch_at_4", 32'(ch), 1);
        check("op_at_4", 32'(op), 1);
      end
      if (m_slot == 13) begin
        check("ch_at_13", 32'(ch), 7);
        check("op_at_13", 32'(op), 0);
      end
      if (m_slot == 0) check("zero_at_wrap", 32'(zero), 1);
    end

    // Slot write to 5 issued while slot 9 is current
    run_to_slot(9);
    wr = 1; wr_glb = 0; wr_slot = 5; wr_sel = 2; wr_data = 8'hA5;
    n0 = applied.size();
    tick();
    wr = 0;
    cnt = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      cnt++;
      if (upd_en === 1'b1) check("upd_en_slot", 32'(slot), 5);
      tick();
      guard++;
    end
    check("busy_len_14", cnt, 14);
    check("apply_count_a", applied.size() - n0, 1);
    if (applied.size() > n0) check("apply_data_a5", applied[n0], 8'hA5);

    // Global write with cen every 4th clk; the slot target is ignored
    cen = 0;
    wr = 1; wr_glb = 1; wr_slot = 5'(m_slot + 3); wr_sel = 3; wr_data = 8'h5C;
    tick();
    wr = 0;
    check("glb_upd_en_now", 32'(upd_en), 1);
    cyc = 0;
    guard = 0;
    while (m_busy && guard < 20) begin
      cen = (cyc % 4 == 3);
      tick();
      if (cen) check("glb_busy_after_cen", 32'(busy), 0);
      cyc++;
      guard++;
    end
    check("glb_applied_sel", 32'(upd_sel), 3);

    // Second requests while busy, including on the apply edge, are dropped
    cen = 1;
    wr = 1; wr_glb = 0; wr_slot = 12; wr_sel = 1; wr_data = 8'h3C;
    n0 = applied.size();
    tick();
    guard = 0;
    while (m_busy && guard < 40) begin
      wr = 1; wr_slot = 5'($urandom_range(0, SLOTS - 1));
      wr_data = 8'(8'h77 ^ guard);
      tick();
      guard++;
    end
    wr = 0;
    check("drop_apply_count", applied.size() - n0, 1);
    if (applied.size() > n0) check("drop_first_data", applied[n0], 8'h3C);
    check("drop_busy_low", 32'(busy), 0);

    // Out-of-range slot target is never accepted
    wr = 1; wr_glb = 0; wr_slot = 20; wr_data = 8'hEE;
    tick();
    wr = 0;
    check("invalid_slot_busy", 32'(busy), 0);

    // Pending write to slot 2 killed by reset before slot 2 comes round
    run_to_slot(5);
    wr = 1; wr_glb = 0; wr_slot = 2; wr_data = 8'h42;
    tick();
    wr = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    check("rst_busy", 32'(busy), 0);
    check("rst_slot", 32'(slot), 0);
    cnt = 0;
    for (int i = 0; i < 2 * SLOTS; i++) begin
      tick();
      if (upd_en === 1'b1) cnt++;
    end
    check("rst_no_upd_en", cnt, 0);

    // cen held low with a write pending to the current slot
    cen = 0;
    saved = m_slot;
    wr = 1; wr_glb = 0; wr_slot = 5'(m_slot); wr_data = 8'h99;
    tick();
    wr = 0;
    check("frozen_upd_en_now", 32'(upd_en), 1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (upd_en === 1'b1 && busy === 1'b1 && int'(slot) == saved) cnt++;
    end
    check("frozen_hold_100", cnt, 100);
    n0 = applied.size();
    cen = 1;
    tick();
    check("frozen_apply_busy", 32'(busy), 0);
    check("frozen_apply_count", applied.size() - n0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      cen     = ($urandom_range(0, 2) != 0);
      wr      = ($urandom_range(0, 3) == 0);
      wr_glb  = ($urandom_range(0, 4) == 0);
      wr_slot = 5'($urandom_range(0, 23));
      wr_sel  = 3'($urandom);
      wr_data = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
